pci_target: RTL and testbench

- Registered PCI-style memory target on the shared bus, downstream of the initiators and their global FRAME/IRDY mux.
- Decodes address phases, claims hits with fast DEVSEL and runs single or linear-burst memory read/write against an internal word array.
- Issues TRDY handshakes and disconnects bursts that run off the end of its window.
- Exports an ownership flag so the bus mux can select its AD/TRDY/DEVSEL/STOP drivers.

---
 rtl/pci_target.sv | 95 +++++++++
 tb/tb_pci_target.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pci_target.sv
// pci_target: registered PCI-style memory target with linear bursts and window-end disconnect
module pci_target #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          ADDR_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic [31:0] ad_in,
  input  logic [3:0]  cbe_n,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        stop_n,
  output logic        i_am_target
);
  typedef enum logic [2:0] {IDLE, BUSY, TURN, XFER, BACKOFF, RELEASE} state_t;
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, idx_nx, start;
  logic [31:0]       ad_out_q, ad_out_d;
  logic              ad_oe_q, ad_oe_d, devsel_q, devsel_d, trdy_q, trdy_d;
  logic              stop_q, stop_d, tgt_q, tgt_d, rd_q, rd_d;
  logic              cmd_rd, cmd_wr, hit, addr_hit, xfer;
  logic [31:0]       mem_q [2**ADDR_W];
  assign cmd_rd   = cbe_n == 4'b0110;
  assign cmd_wr   = cbe_n == 4'b0111;
  assign hit      = (ad_in[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) && (cmd_rd || cmd_wr);
  assign start    = ad_in[ADDR_W+1:2];
  assign addr_hit = state_q == IDLE && !frame_n && hit;
  assign xfer     = state_q == XFER && !irdy_n && !trdy_q;
  assign idx_nx   = idx_q + ADDR_W'(1);
  assign ad_out      = ad_out_q;
  assign ad_oe       = ad_oe_q;
  assign devsel_n    = devsel_q;
  assign trdy_n      = trdy_q;
  assign stop_n      = stop_q;
  assign i_am_target = tgt_q;
  // State and registered bus outputs; reset drops every bus driver immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      tgt_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      devsel_q <= devsel_d;
      trdy_q   <= trdy_d;
      stop_q   <= stop_d;
      tgt_q    <= tgt_d;
      rd_q     <= rd_d;
    end
  end
  // Next state: decode only from IDLE, leave XFER on the last or window-end transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!frame_n) state_d = !hit ? BUSY : cmd_wr ? XFER : TURN;
      BUSY:    if (frame_n && irdy_n) state_d = IDLE;
      TURN:    state_d = XFER;
      XFER:    if (xfer) state_d = frame_n ? RELEASE : idx_q == LAST ? BACKOFF : XFER;
      BACKOFF: if (frame_n) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs for the coming cycle follow the next state; index and read data advance per transfer
  always_comb begin
    idx_d    = addr_hit ? start : xfer && idx_q != LAST ? idx_nx : idx_q;
    rd_d     = addr_hit ? cmd_rd : rd_q;
    ad_out_d = state_q == TURN ? mem_q[idx_q] : xfer && rd_q ? mem_q[idx_nx] : ad_out_q;
    tgt_d    = state_d inside {TURN, XFER, BACKOFF, RELEASE};
    devsel_d = !(state_d inside {TURN, XFER, BACKOFF});
    trdy_d   = state_d != XFER;
    stop_d   = !(state_d == BACKOFF || (state_d == XFER && idx_d == LAST));
    ad_oe_d  = state_d == XFER && rd_d;
  end
  // Word array with byte-enabled writes on write transfer edges; never reset
  always_ff @(posedge clk) begin
    if (xfer && !rd_q)
      for (int b = 0; b < 4; b++)
        if (!cbe_n[b]) mem_q[idx_q][8*b+:8] <= ad_in[8*b+:8];
  end
endmodule

// File: tb/tb_pci_target.sv
// tb_pci_target: directed vector table plus hand-written burst, disconnect and reset sequences
module tb_pci_target;
  logic        clk = 1'b0, rst_n = 1'b0, frame_n = 1'b1, irdy_n = 1'b1;
  logic [31:0] ad_in = '0;
  logic [3:0]  cbe_n = 4'hF;
  logic [31:0] ad_out;
  logic        ad_oe, devsel_n, trdy_n, stop_n, i_am_target;
  logic [4:0]  ctl;
  int          total = 0, bad = 0;

  typedef struct {
    logic        fr, ir;
    logic [31:0] ad;
    logic [3:0]  cbe;
    logic [4:0]  ctl;
    logic        chk_ad;
    logic [31:0] exp_ad;
  } vec_t;
  vec_t vq[$];

  localparam logic [4:0] C_IDLE = 5'b11100, C_WR = 5'b00101, C_TURN = 5'b01101,
                         C_RD = 5'b00111, C_REL = 5'b11101, C_BACK = 5'b01001, C_WLAST = 5'b00001;

  pci_target dut (
    .clk(clk), .rst_n(rst_n), .frame_n(frame_n), .irdy_n(irdy_n), .ad_in(ad_in), .cbe_n(cbe_n),
    .ad_out(ad_out), .ad_oe(ad_oe), .devsel_n(devsel_n), .trdy_n(trdy_n), .stop_n(stop_n),
    .i_am_target(i_am_target)
  );

  always #5 clk = ~clk;
  assign ctl = {devsel_n, trdy_n, stop_n, ad_oe, i_am_target};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic s(input logic fr, input logic ir, input logic [31:0] ad, input logic [3:0] cbe);
    frame_n = fr; irdy_n = ir; ad_in = ad; cbe_n = cbe;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] cbe);
    s(0, 1, addr, 4'b0111);
    s(1, 0, data, cbe);
    s(1, 1, 0, 4'hF);
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    s(0, 1, addr, 4'b0110);
    s(1, 0, 0, 4'h0);
    chk(name, ad_out, exp);
    s(1, 0, 0, 4'h0);
    s(1, 1, 0, 4'hF);
  endtask

  task automatic add(input logic fr, input logic ir, input logic [31:0] ad, input logic [3:0] cbe,
                     input logic [4:0] c, input logic ca, input logic [31:0] ea);
    vq.push_back('{fr, ir, ad, cbe, c, ca, ea});
  endtask

  initial begin
    // single write then read of 0x1008
    add(0, 1, 32'h1008, 4'b0111, C_WR, 0, 0);
    add(1, 0, 32'hDEADBEEF, 4'b0000, C_REL, 0, 0);
    add(1, 1, 0, 4'hF, C_IDLE, 0, 0);
    add(0, 1, 32'h1008, 4'b0110, C_TURN, 0, 0);
    add(1, 0, 0, 4'h0, C_RD, 1, 32'hDEADBEEF);
    add(1, 0, 0, 4'h0, C_REL, 0, 0);
    add(1, 1, 0, 4'hF, C_IDLE, 0, 0);
    // preload then byte-enabled overwrite of 0x1000, back-to-back after RELEASE
    add(0, 1, 32'h1000, 4'b0111, C_WR, 0, 0);
    add(1, 0, 32'h11223344, 4'b0000, C_REL, 0, 0);
    add(1, 1, 0, 4'hF, C_IDLE, 0, 0);
    add(0, 1, 32'h1000, 4'b0111, C_WR, 0, 0);
    add(1, 0, 32'hAABBCCDD, 4'b1010, C_REL, 0, 0);
    add(1, 1, 0, 4'hF, C_IDLE, 0, 0);
    add(0, 1, 32'h1000, 4'b0110, C_TURN, 0, 0);
    add(1, 0, 0, 4'h0, C_RD, 1, 32'h11BB33DD);
    add(1, 0, 0, 4'h0, C_REL, 0, 0);
    add(1, 1, 0, 4'hF, C_IDLE, 0, 0);
    // miss and ignored command; BUSY must ignore frames until frame_n=irdy_n=1
    add(0, 1, 32'h2000, 4'b0110, C_IDLE, 0, 0);
    add(1, 0, 0, 4'h0, C_IDLE, 0, 0);
    add(0, 1, 32'h1000, 4'b0111, C_IDLE, 0, 0);
    add(1, 1, 0, 4'hF, C_IDLE, 0, 0);
    add(0, 1, 32'h1000, 4'b0010, C_IDLE, 0, 0);
    add(1, 1, 0, 4'hF, C_IDLE, 0, 0);
    add(0, 1, 32'h1000, 4'b0110, C_TURN, 0, 0);
    add(1, 0, 0, 4'h0, C_RD, 1, 32'h11BB33DD);
    add(1, 0, 0, 4'h0, C_REL, 0, 0);
    add(1, 1, 0, 4'hF, C_IDLE, 0, 0);

    repeat (2) @(negedge clk);
    chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
    chk("reset_ad_out", ad_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vq[i]) begin
      s(vq[i].fr, vq[i].ir, vq[i].ad, vq[i].cbe);
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vq[i].ctl));
      if (vq[i].chk_ad) chk($sformatf("vec%0d_ad_out", i), ad_out, vq[i].exp_ad);
    end

    // burst write 1..4 to indices 1..4 with two wait states before word 3
    wr(32'h1014, 32'h55555555, 4'h0);
    s(0, 1, 32'h1004, 4'b0111);
    s(0, 0, 32'd1, 4'h0);
    s(0, 0, 32'd2, 4'h0);
    s(0, 1, 32'hBAD0, 4'h0);
    chk("burst_wait1_ctl", 32'(ctl), 32'(C_WR));
    s(0, 1, 32'hBAD1, 4'h0);
    chk("burst_wait2_ctl", 32'(ctl), 32'(C_WR));
    s(0, 0, 32'd3, 4'h0);
    s(1, 0, 32'd4, 4'h0);
    chk("burst_last_ctl", 32'(ctl), 32'(C_REL));
    s(1, 1, 0, 4'hF);
    // burst read back 1..4
    s(0, 1, 32'h1004, 4'b0110);
    s(0, 0, 0, 4'h0);
    chk("brd_w1", ad_out, 1);
    s(0, 0, 0, 4'h0);
    chk("brd_w2", ad_out, 2);
    s(0, 0, 0, 4'h0);
    chk("brd_w3", ad_out, 3);
    s(0, 0, 0, 4'h0);
    chk("brd_w4", ad_out, 4);
    s(1, 0, 0, 4'h0);
    chk("brd_rel_ctl", 32'(ctl), 32'(C_REL));
    s(1, 1, 0, 4'hF);
    rd("idx5_untouched", 32'h1014, 32'h55555555);
    rd("idx0_untouched", 32'h1000, 32'h11BB33DD);

    // window-end disconnect from 0x1038 with frame_n held low
    s(0, 1, 32'h1038, 4'b0111);
    chk("win_idx14_ctl", 32'(ctl), 32'(C_WR));
    s(0, 0, 32'hE0E0E0E0, 4'h0);
    chk("win_idx15_ctl", 32'(ctl), 32'(C_WLAST));
    s(0, 0, 32'hF0F0F0F0, 4'h0);
    chk("win_backoff_ctl", 32'(ctl), 32'(C_BACK));
    s(0, 0, 32'hBAD00001, 4'h0);
    chk("win_backoff2_ctl", 32'(ctl), 32'(C_BACK));
    s(0, 0, 32'hBAD00002, 4'h0);
    s(1, 1, 0, 4'hF);
    chk("win_release_ctl", 32'(ctl), 32'(C_REL));
    s(1, 1, 0, 4'hF);
    chk("win_idle_ctl", 32'(ctl), 32'(C_IDLE));
    rd("win_idx14", 32'h1038, 32'hE0E0E0E0);
    rd("win_idx15", 32'h103C, 32'hF0F0F0F0);
    rd("win_idx0", 32'h1000, 32'h11BB33DD);

    // asynchronous reset in the middle of a read burst
    s(0, 1, 32'h1004, 4'b0110);
    s(0, 0, 0, 4'h0);
    chk("rst_pre_ctl", 32'(ctl), 32'(C_RD));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rst_async_ad_out", ad_out, 0);
    frame_n = 1'b1; irdy_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr(32'h1010, 32'h12345678, 4'h0);
    rd("post_rst_rd", 32'h1010, 32'h12345678);
    rd("post_rst_idx1", 32'h1004, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
